// File: rtl/coeff_loader.sv
// rtl/coeff_loader.sv - serial byte loader for the 5x5 filter-coefficient bus with atomic commit
module coeff_loader #(
  parameter int N_COEFF = 25,
  parameter int C_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  input  logic [C_W-1:0]         s_data,
  input  logic                   s_first,
  output logic                   s_ready,
  input  logic                   swap_ok,
  output logic [N_COEFF*C_W-1:0] f_coeff,
  output logic                   coeff_valid,
  output logic                   pend,
  output logic                   err
);

  localparam int F_W   = N_COEFF * C_W;
  localparam int IDX_W = $clog2(N_COEFF);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEFF - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [C_W-1:0]   shadow [N_COEFF];
  logic             xfer;

  // The stream is only blocked while a finished kernel waits for its commit.
  assign s_ready = (state != PEND) && !rst;
  assign xfer    = s_valid && s_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode from the current state, the accepted byte and swap_ok.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (xfer && s_first) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (xfer && !s_first && idx == LAST_IDX) begin
          state_next = PEND;
        end
      end
      PEND: begin
        if (swap_ok) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow assembly, index tracking, commit into f_coeff and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      f_coeff     <= '0;
      coeff_valid <= 1'b0;
      pend        <= 1'b0;
      err         <= 1'b0;
      for (int k = 0; k < N_COEFF; k++) begin
        shadow[k] <= '0;
      end
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (s_first) begin
              shadow[0] <= s_data;
              idx       <= ONE_IDX;
            end else begin
              // A byte with no framing start cannot be placed; drop it.
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            if (s_first) begin
              // Restart: stale bytes beyond coefficient 0 get overwritten
              // before this kernel can reach PEND.
              shadow[0] <= s_data;
              idx       <= ONE_IDX;
              err       <= 1'b1;
            end else begin
              shadow[idx] <= s_data;
              if (idx == LAST_IDX) begin
                idx  <= '0;
                pend <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
        end
        PEND: begin
          if (swap_ok) begin
            for (int k = 0; k < N_COEFF; k++) begin
              f_coeff[C_W*k +: C_W] <= shadow[k];
            end
            coeff_valid <= 1'b1;
            pend        <= 1'b0;
          end
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = (F_W == N_COEFF * C_W);

endmodule
